// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: register index type and hazard FSM state.
package cpu_types_pkg;

  // 5-bit architectural register index
  typedef logic [4:0] regbits_t;

  // Hazard controller states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LDSTALL = 2'd1,
    DWAIT   = 2'd2,
    HALTED  = 2'd3
  } hazard_state_t;

  // A load in EX whose destination feeds an ID-stage source; r0 never hazards
  function automatic logic load_use_hit(
    input logic     ex_memRd,
    input regbits_t ex_rt,
    input regbits_t id_rs,
    input regbits_t id_rt
  );
    return ex_memRd && (ex_rt != '0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating event counter used for hazard controller performance statistics.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // Count qualifying cycles, holding at all-ones once reached
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: stalls, flushes and halt for a 5-stage pipeline.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_controller
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             ex_memRd,
  input  regbits_t         ex_rt,
  input  regbits_t         id_rs,
  input  regbits_t         id_rt,
  input  logic             mem_pcsrc,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state, next_state;
  logic          data_wait;
  logic          load_use;
  logic          flush_applied;

  // The data-wait term is evaluated from live inputs in every state, so DWAIT
  // decodes exactly like RUN; it only records that the MEM stage is blocked.
  assign data_wait = (mem_dREN || mem_dWEN) && !dhit;
  assign load_use  = load_use_hit(ex_memRd, ex_rt, id_rs, id_rt) && (state != LDSTALL);
  assign halted    = (state == HALTED);

  // State register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // Prioritised event decode: halt > data wait > branch > load-use > fetch miss
  always_comb begin
    pc_en         = 1'b1;
    ifid_en       = 1'b1;
    idex_en       = 1'b1;
    exmem_en      = 1'b1;
    memwb_en      = 1'b1;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    flush_applied = 1'b0;
    next_state    = RUN;

    if ((state == HALTED) || wb_halt) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      next_state = HALTED;
    end else if (data_wait) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      next_state = DWAIT;
    end else if (mem_pcsrc) begin
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      exmem_flush   = 1'b1;
      flush_applied = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      next_state = LDSTALL;
    end else if (!ihit) begin
      pc_en      = 1'b0;
      ifid_flush = 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic stall_inc;

  assign stall_inc = !pc_en && (state != HALTED);

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .cnt  (stall_cnt)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush_applied),
    .cnt  (flush_cnt)
  );
`else
  logic unused_flush;

  assign unused_flush = flush_applied;
  assign stall_cnt    = '0;
  assign flush_cnt    = '0;
`endif

endmodule
